// File: rtl/alfa_pc_sched_pkg.sv
// Shared definitions for the ALFA point-cloud scheduler: FSM states,
// point-word field positions and point size in memory.
package alfa_pc_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_CMD   = 3'd1,
    RD_DATA  = 3'd2,
    WAIT_RES = 3'd3,
    WR_CMD   = 3'd4,
    WR_DATA  = 3'd5,
    WR_RESP  = 3'd6,
    DONE     = 3'd7
  } state_e;

  // Field positions inside a 64-bit point word
  localparam int X_LSB     = 0;
  localparam int X_MSB     = 15;
  localparam int Y_LSB     = 16;
  localparam int Y_MSB     = 31;
  localparam int Z_LSB     = 32;
  localparam int Z_MSB     = 47;
  localparam int LABEL_LSB = 56;
  localparam int LABEL_MSB = 63;

  // One point occupies one 8-byte memory word
  localparam int POINT_BYTES = 8;

endpackage

// File: rtl/alfa_pc_chunk_fifo.sv
// Chunk FIFO: holds the processed points of one burst until they are
// written back. DEPTH must be a power of two so the pointers wrap freely.
module alfa_pc_chunk_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 64,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage write
  // NOTE: the data array has no reset; only pointers and count are reset,
  // since stale entries are never visible while the count says empty.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointer and occupancy bookkeeping
  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/alfa_pc_scheduler.sv
// ALFA point-cloud scheduler: on a rising edge of pc_ready it streams the
// point cloud chunk by chunk from memory through the extension core and
// writes results back in place, then raises a sticky done flag.
// Optional busy-cycle counter enabled by defining ALFA_PC_SCHED_PERF_EN.
module alfa_pc_scheduler
  import alfa_pc_sched_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int POINT_W   = 64,
  parameter int CNT_W     = 20,
  parameter int BURST_LEN = 16
) (
  input  logic               i_SYSTEM_clk,
  input  logic               i_SYSTEM_rst,
  input  logic [ADDR_W-1:0]  i_cfg_base_addr,
  input  logic [CNT_W-1:0]   i_cfg_num_points,
  input  logic               i_cfg_pc_ready,
  output logic               o_status_busy,
  output logic               o_status_done,
  output logic [CNT_W-1:0]   o_points_done,
  output logic               o_cmd_valid,
  input  logic               i_cmd_ready,
  output logic               o_cmd_write,
  output logic [ADDR_W-1:0]  o_cmd_addr,
  output logic [7:0]         o_cmd_len,
  input  logic               i_rd_valid,
  output logic               o_rd_ready,
  input  logic [POINT_W-1:0] i_rd_data,
  input  logic               i_rd_last,
  output logic               o_ext_valid,
  input  logic               i_ext_ready,
  output logic [POINT_W-1:0] o_ext_data,
  input  logic               i_res_valid,
  output logic               o_res_ready,
  input  logic [POINT_W-1:0] i_res_data,
  output logic               o_wr_valid,
  input  logic               i_wr_ready,
  output logic [POINT_W-1:0] o_wr_data,
  output logic               o_wr_last,
  input  logic               i_bresp_valid,
  output logic [31:0]        o_perf_cycles
);

  localparam int LEN_W = $clog2(BURST_LEN) + 1;

  state_e             r_state;
  logic               r_pc_ready_q;
  logic [ADDR_W-1:0]  r_addr;
  logic [CNT_W-1:0]   r_remaining;
  logic [CNT_W-1:0]   r_points_done;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_wr_beat;
  logic               r_busy;
  logic               r_done;

  logic               w_start;
  logic               w_rd_phase;
  logic               w_cmd_phase;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [LEN_W-1:0]   w_fifo_count;
  logic [POINT_W-1:0] w_fifo_head;
  logic               w_res_fire;
  logic               w_wr_fire;
  logic [LEN_W-1:0]   w_len_m1;
  logic [CNT_W-1:0]   w_rem_next;

  // Points in the next chunk: a full burst or whatever is left
  function automatic logic [LEN_W-1:0] chunk_len(input logic [CNT_W-1:0] rem);
    if (rem >= CNT_W'(BURST_LEN)) return LEN_W'(BURST_LEN);
    else                          return LEN_W'(rem);
  endfunction

  assign w_start     = i_cfg_pc_ready & ~r_pc_ready_q;
  assign w_rd_phase  = (r_state == RD_DATA);
  assign w_cmd_phase = (r_state == RD_CMD) || (r_state == WR_CMD);
  assign w_len_m1    = r_len - 1'b1;
  assign w_rem_next  = r_remaining - CNT_W'(r_len);

  // Command channel is a pure decode of held registers, so it cannot
  // change or drop while waiting for i_cmd_ready.
  assign o_cmd_valid = w_cmd_phase;
  assign o_cmd_write = (r_state == WR_CMD);
  assign o_cmd_addr  = w_cmd_phase ? r_addr : '0;
  assign o_cmd_len   = w_cmd_phase ? 8'(w_len_m1) : 8'd0;

  // Read beats flow straight into the extension with no buffering
  assign o_ext_valid = w_rd_phase & i_rd_valid;
  assign o_ext_data  = w_rd_phase ? i_rd_data : '0;
  assign o_rd_ready  = w_rd_phase & i_ext_ready;

  // Results accepted only while a chunk is being processed
  assign o_res_ready = ((r_state == RD_DATA) || (r_state == WAIT_RES)) & ~w_fifo_full;
  assign w_res_fire  = i_res_valid & o_res_ready;

  // Write beats drain the chunk FIFO in order
  assign o_wr_valid  = (r_state == WR_DATA) & ~w_fifo_empty;
  assign o_wr_data   = o_wr_valid ? w_fifo_head : '0;
  assign o_wr_last   = o_wr_valid & (r_wr_beat == w_len_m1);
  assign w_wr_fire   = o_wr_valid & i_wr_ready;

  assign o_status_busy = r_busy;
  assign o_status_done = r_done;
  assign o_points_done = r_points_done;

  alfa_pc_chunk_fifo #(
    .DEPTH (BURST_LEN),
    .WIDTH (POINT_W)
  ) u_chunk_fifo (
    .i_clk       (i_SYSTEM_clk),
    .i_rst_n     (i_SYSTEM_rst),
    .i_push      (w_res_fire),
    .i_push_data (i_res_data),
    .i_pop       (w_wr_fire),
    .o_head      (w_fifo_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  // Run sequencer: chunk address/length bookkeeping and status flags
  always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
    if (!i_SYSTEM_rst) begin
      r_state       <= IDLE;
      r_pc_ready_q  <= 1'b0;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_points_done <= '0;
      r_len         <= '0;
      r_wr_beat     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_pc_ready_q <= i_cfg_pc_ready;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_done        <= 1'b0;
            r_busy        <= 1'b1;
            r_addr        <= i_cfg_base_addr & ~ADDR_W'(7);
            r_remaining   <= i_cfg_num_points;
            r_points_done <= '0;
            r_len         <= chunk_len(i_cfg_num_points);
            r_state       <= (i_cfg_num_points == '0) ? DONE : RD_CMD;
          end
        end
        RD_CMD: begin
          if (i_cmd_ready) r_state <= RD_DATA;
        end
        RD_DATA: begin
          if (i_rd_valid && i_ext_ready && i_rd_last) r_state <= WAIT_RES;
        end
        WAIT_RES: begin
          if (w_fifo_count == r_len) r_state <= WR_CMD;
        end
        WR_CMD: begin
          if (i_cmd_ready) begin
            r_wr_beat <= '0;
            r_state   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_wr_fire) begin
            r_wr_beat <= r_wr_beat + 1'b1;
            if (o_wr_last) r_state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (i_bresp_valid) begin
            r_addr        <= r_addr + ADDR_W'(r_len) * ADDR_W'(POINT_BYTES);
            r_remaining   <= w_rem_next;
            r_points_done <= r_points_done + CNT_W'(r_len);
            r_len         <= chunk_len(w_rem_next);
            r_state       <= (w_rem_next == '0) ? DONE : RD_CMD;
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ALFA_PC_SCHED_PERF_EN
  logic [31:0] r_perf_cycles;

  // Saturating busy-cycle counter, cleared when a run starts
  always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
    if (!i_SYSTEM_rst) begin
      r_perf_cycles <= '0;
    end else if ((r_state == IDLE) && w_start) begin
      r_perf_cycles <= '0;
    end else if (r_busy && (r_perf_cycles != 32'hFFFF_FFFF)) begin
      r_perf_cycles <= r_perf_cycles + 32'd1;
    end
  end

  assign o_perf_cycles = r_perf_cycles;
`else
  assign o_perf_cycles = '0;
`endif

endmodule

// File: tb/tb_alfa_pc_scheduler.sv
// Testbench for alfa_pc_scheduler: behavioural memory and extension models
// with random stalls, a scoreboard of expected commands and write beats
// built from the chunking rules, and a decoupled monitor that compares.
module tb_alfa_pc_scheduler;
  import alfa_pc_sched_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int POINT_W   = 64;
  localparam int CNT_W     = 20;
  localparam int BURST_LEN = 16;
  localparam int MEM_WORDS = 4096;
  localparam int TIMEOUT   = 15000;

  logic               clk;
  logic               rst_n;
  logic [ADDR_W-1:0]  i_cfg_base_addr;
  logic [CNT_W-1:0]   i_cfg_num_points;
  logic               i_cfg_pc_ready;
  logic               o_status_busy, o_status_done;
  logic [CNT_W-1:0]   o_points_done;
  logic               o_cmd_valid, i_cmd_ready, o_cmd_write;
  logic [ADDR_W-1:0]  o_cmd_addr;
  logic [7:0]         o_cmd_len;
  logic               i_rd_valid, o_rd_ready, i_rd_last;
  logic [POINT_W-1:0] i_rd_data;
  logic               o_ext_valid, i_ext_ready;
  logic [POINT_W-1:0] o_ext_data;
  logic               i_res_valid, o_res_ready;
  logic [POINT_W-1:0] i_res_data;
  logic               o_wr_valid, i_wr_ready, o_wr_last;
  logic [POINT_W-1:0] o_wr_data;
  logic               i_bresp_valid;
  logic [31:0]        o_perf_cycles;

  alfa_pc_scheduler #(
    .ADDR_W(ADDR_W), .POINT_W(POINT_W), .CNT_W(CNT_W), .BURST_LEN(BURST_LEN)
  ) dut (
    .i_SYSTEM_clk(clk), .i_SYSTEM_rst(rst_n),
    .i_cfg_base_addr(i_cfg_base_addr), .i_cfg_num_points(i_cfg_num_points),
    .i_cfg_pc_ready(i_cfg_pc_ready),
    .o_status_busy(o_status_busy), .o_status_done(o_status_done),
    .o_points_done(o_points_done),
    .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready), .o_cmd_write(o_cmd_write),
    .o_cmd_addr(o_cmd_addr), .o_cmd_len(o_cmd_len),
    .i_rd_valid(i_rd_valid), .o_rd_ready(o_rd_ready), .i_rd_data(i_rd_data),
    .i_rd_last(i_rd_last),
    .o_ext_valid(o_ext_valid), .i_ext_ready(i_ext_ready), .o_ext_data(o_ext_data),
    .i_res_valid(i_res_valid), .o_res_ready(o_res_ready), .i_res_data(i_res_data),
    .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready), .o_wr_data(o_wr_data),
    .o_wr_last(o_wr_last), .i_bresp_valid(i_bresp_valid),
    .o_perf_cycles(o_perf_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Memory contents, expected final image, and scoreboard queues
  logic [63:0] mem     [MEM_WORDS];
  logic [63:0] exp_img [MEM_WORDS];
  logic [40:0] exp_cmd [$];   // {write, addr, len-1}
  logic [64:0] exp_wr  [$];   // {last, data}
  int          busy_cnt  = 0;
  int          n_rd_cmd  = 0;

  // Environment knobs (percent probabilities)
  int p_cmd = 70, p_rd = 70, p_ext = 70, p_res = 70, p_wr = 70;
  int cmd_stall = 0;
  bit wr_toggle = 1'b0;
  bit set_label = 1'b0;

  // Memory slave and extension model state
  typedef struct { logic [63:0] data; logic last; } beat_t;
  beat_t       rd_q  [$];
  logic [63:0] res_q [$];
  logic [31:0] wr_addr = '0;
  int          wr_left = 0;
  int          bresp_delay = -1;
  int          cmd_wait = 0;

  function automatic bit coin(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  // Bus models: drive inputs at the falling edge, then resolve handshakes
  // that the coming rising edge will perform.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_q.delete(); res_q.delete();
      wr_left = 0; bresp_delay = -1; cmd_wait = 0;
      i_cmd_ready = 0; i_rd_valid = 0; i_rd_data = '0; i_rd_last = 0;
      i_ext_ready = 0; i_res_valid = 0; i_res_data = '0;
      i_wr_ready = 0; i_bresp_valid = 0;
    end else begin
      i_cmd_ready   = (cmd_stall > 0) ? (cmd_wait >= cmd_stall) : coin(p_cmd);
      i_rd_valid    = (rd_q.size() > 0) && coin(p_rd);
      i_rd_data     = (rd_q.size() > 0) ? rd_q[0].data : '0;
      i_rd_last     = (rd_q.size() > 0) ? rd_q[0].last : 1'b0;
      i_ext_ready   = coin(p_ext);
      i_res_valid   = (res_q.size() > 0) && coin(p_res);
      i_res_data    = (res_q.size() > 0) ? res_q[0] : '0;
      i_wr_ready    = wr_toggle ? ~i_wr_ready : coin(p_wr);
      i_bresp_valid = (bresp_delay == 0);
      if (bresp_delay >= 0) bresp_delay--;
      #1;
      if (o_cmd_valid) begin
        if (i_cmd_ready) begin
          cmd_wait = 0;
          if (o_cmd_write) begin
            wr_addr = o_cmd_addr;
            wr_left = int'(o_cmd_len) + 1;
          end else begin
            for (int i = 0; i <= int'(o_cmd_len); i++) begin
              beat_t b;
              b.data = mem[(int'(o_cmd_addr >> 3) + i) % MEM_WORDS];
              b.last = (i == int'(o_cmd_len));
              rd_q.push_back(b);
            end
          end
        end else begin
          cmd_wait++;
        end
      end
      if (i_rd_valid && o_rd_ready) void'(rd_q.pop_front());
      if (i_res_valid && o_res_ready) void'(res_q.pop_front());
      if (o_ext_valid && i_ext_ready) begin
        logic [63:0] r;
        r = o_ext_data;
        if (set_label) r[LABEL_MSB:LABEL_LSB] = 8'h01;
        res_q.push_back(r);
      end
      if (o_wr_valid && i_wr_ready) begin
        mem[int'(wr_addr >> 3) % MEM_WORDS] = o_wr_data;
        wr_addr += 32'd8;
        wr_left--;
        if (wr_left == 0) bresp_delay = $urandom_range(4) + 1;
      end
    end
  end

  // Monitor: compares DUT traffic against the scoreboard queues
  logic        cmd_pend = 1'b0;
  logic [40:0] cmd_prev = '0;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      cmd_pend = 1'b0;
    end else begin
      if (o_status_busy) busy_cnt++;
      if (cmd_pend)
        check("cmd_hold", {o_cmd_valid, o_cmd_write, o_cmd_addr, o_cmd_len}, {1'b1, cmd_prev});
      if (o_cmd_valid && i_cmd_ready) begin
        if (!o_cmd_write) n_rd_cmd++;
        if (exp_cmd.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_cmd: actual=0x%0h expected=none",
                   {o_cmd_write, o_cmd_addr, o_cmd_len});
        end else begin
          check("cmd", {o_cmd_write, o_cmd_addr, o_cmd_len}, exp_cmd.pop_front());
        end
      end
      cmd_pend = o_cmd_valid && !i_cmd_ready;
      cmd_prev = {o_cmd_write, o_cmd_addr, o_cmd_len};
      if (o_wr_valid && i_wr_ready) begin
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_wr: actual=0x%0h expected=none", o_wr_data);
        end else begin
          logic [64:0] e;
          e = exp_wr.pop_front();
          check("wr_data", o_wr_data, e[63:0]);
          check("wr_last", o_wr_last, e[64]);
        end
      end
    end
  end

  // Build the expected traffic from the chunking rules, then pulse pc_ready
  task automatic run_start(input logic [31:0] base, input int n);
    logic [31:0] a;
    int          rem, len, idx;
    logic [63:0] d;
    i_cfg_base_addr  = base;
    i_cfg_num_points = CNT_W'(n);
    exp_img = mem;
    a   = base & ~32'h7;
    rem = n;
    while (rem > 0) begin
      len = (rem > BURST_LEN) ? BURST_LEN : rem;
      exp_cmd.push_back({1'b0, a, 8'(len - 1)});
      exp_cmd.push_back({1'b1, a, 8'(len - 1)});
      for (int j = 0; j < len; j++) begin
        idx = (int'(a >> 3) + j) % MEM_WORDS;
        d   = mem[idx];
        if (set_label) d[63:56] = 8'h01;
        exp_img[idx] = d;
        exp_wr.push_back({(j == len - 1), d});
      end
      a   += 32'(len * 8);
      rem -= len;
    end
    @(negedge clk); i_cfg_pc_ready = 1'b0;
    busy_cnt = 0; n_rd_cmd = 0;
    @(negedge clk); i_cfg_pc_ready = 1'b1;
    @(negedge clk); #3;
    check("start_done_clear", o_status_done, 1'b0);
    check("start_busy", o_status_busy, 1'b1);
  endtask

  task automatic wait_done();
    int c = 0;
    while (o_status_done !== 1'b1 && c < TIMEOUT) begin
      @(negedge clk); #3;
      c++;
    end
    check("run_done", o_status_done, 1'b1);
  endtask

  task automatic finish_checks(input int n);
    int mism = 0;
    check("points_done", o_points_done, 64'(n));
    check("busy_after", o_status_busy, 1'b0);
    check("cmd_left", exp_cmd.size(), 0);
    check("wr_left", exp_wr.size(), 0);
    for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== exp_img[i]) mism++;
    check("mem_image", mism, 0);
`ifdef ALFA_PC_SCHED_PERF_EN
    check("perf_cycles", o_perf_cycles, 64'(busy_cnt));
`else
    check("perf_cycles", o_perf_cycles, 0);
`endif
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_ctrl"}, {o_status_busy, o_status_done, o_cmd_valid, o_cmd_write,
                           o_rd_ready, o_ext_valid, o_res_ready, o_wr_valid, o_wr_last}, 0);
    check({tag, "_points"}, o_points_done, 0);
    check({tag, "_cmd"}, {o_cmd_addr, o_cmd_len}, 0);
    check({tag, "_perf"}, o_perf_cycles, 0);
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    i_cfg_pc_ready = 1'b0;
    i_cfg_base_addr = '0;
    i_cfg_num_points = '0;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = {$urandom, $urandom};

    repeat (3) @(negedge clk);
    #3 outputs_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // 1000 points from address 0, identity extension
    run_start(32'h0, 1000);
    wait_done();
    finish_checks(1000);
    check("rd_cmd_count_1000", n_rd_cmd, 63);

    // Zero points: no traffic, done two cycles after the pc_ready edge
    run_start(32'h100, 0);
    @(negedge clk); #3;
    check("zero_done", o_status_done, 1'b1);
    finish_checks(0);
    check("zero_rd_cmds", n_rd_cmd, 0);

    // Labelling extension with 50% stalls; low address bits ignored
    set_label = 1'b1;
    p_rd = 50; p_ext = 50; p_res = 50; p_wr = 50; p_cmd = 50;
    run_start(32'h2003, 100);
    wait_done();
    finish_checks(100);

    // Long command stalls, toggling write-ready, pc_ready re-edge mid-run
    set_label = 1'b0;
    cmd_stall = 10; wr_toggle = 1'b1;
    run_start(32'h1000, 48);
    repeat (30) @(negedge clk);
    i_cfg_pc_ready = 1'b0;
    repeat (3) @(negedge clk);
    i_cfg_pc_ready = 1'b1;
    wait_done();
    finish_checks(48);
    check("reedge_rd_cmds", n_rd_cmd, 3);

    // Reset in the middle of a write burst, then a fresh 20-point run
    cmd_stall = 0; wr_toggle = 1'b0;
    p_rd = 80; p_ext = 80; p_res = 80; p_wr = 60; p_cmd = 80;
    run_start(32'h0, 1000);
    c = 0;
    while (!o_wr_valid && c < TIMEOUT) begin @(negedge clk); #3; c++; end
    check("reach_wr_data", o_wr_valid, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    i_cfg_pc_ready = 1'b0;
    #3 outputs_zero("rst_mid");
    exp_cmd.delete(); exp_wr.delete();
    repeat (3) @(negedge clk);
    #3 outputs_zero("rst_hold");
    @(negedge clk); rst_n = 1'b1;
    run_start(32'h6000, 20);
    wait_done();
    finish_checks(20);
    check("post_rst_rd_cmds", n_rd_cmd, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alfa_pc_scheduler.md
Name: alfa_pc_scheduler

Overview:
Sequencer that moves a point cloud held in DDR through the ALFA extension datapath and writes the results back in place. It sits between the MonU configuration registers, a burst-level memory adapter (AXI master shim) and the extension core. On a rising edge of pc_ready it runs read-chunk / process / write-chunk cycles until every point is done, then raises done (MonU reg 9).

Parameters:
ADDR_W, 32, memory byte-address width
POINT_W, 64, point word width: x[15:0], y[31:16], z[47:32], label[63:56]
CNT_W, 20, point-count width
BURST_LEN, 16, maximum points per chunk (power of 2, 2..256)

Ports:
i_SYSTEM_clk  in  1  system clock
i_SYSTEM_rst  in  1  reset, asynchronous, active-low
i_cfg_base_addr  in  ADDR_W  point-cloud base byte address; bits [2:0] ignored
i_cfg_num_points  in  CNT_W  number of points (MonU reg 37)
i_cfg_pc_ready  in  1  level from MonU reg 35; a rising edge starts a run
o_status_busy  out  1  run in progress
o_status_done  out  1  sticky completion flag (MonU reg 9)
o_points_done  out  CNT_W  points written back in the current run
o_cmd_valid / i_cmd_ready  out/in  1  memory command handshake
o_cmd_write  out  1  1 = write burst, 0 = read burst
o_cmd_addr  out  ADDR_W  burst start address
o_cmd_len  out  8  beats minus 1
i_rd_valid / o_rd_ready  in/out  1  read-data handshake
i_rd_data  in  POINT_W  read beat
i_rd_last  in  1  last beat of read burst
o_ext_valid / i_ext_ready  out/in  1  point to extension
o_ext_data  out  POINT_W  point to extension
i_res_valid / o_res_ready  in/out  1  result from extension
i_res_data  in  POINT_W  processed point
o_wr_valid / i_wr_ready  out/in  1  write-data handshake
o_wr_data  out  POINT_W  write beat
o_wr_last  out  1  last beat of write burst
i_bresp_valid  in  1  write response (always accepted)
o_perf_cycles  out  32  busy-cycle count (see Optional Feature)

Behaviour:
- Reset: all outputs 0; FSM IDLE; internal counters and FIFO cleared. Reset mid-run aborts the run with no drain; done stays 0.
- Start: pc_ready registered; start = pc_ready & ~pc_ready_q. done clears on start. Edges while busy are ignored.
- Chunk length len = min(BURST_LEN, remaining).
- IDLE: on start, latch addr = base & ~7 and remaining = num_points. If remaining == 0, go to DONE; otherwise go to RD_CMD.
- RD_CMD: o_cmd_valid=1, write=0, addr, len-1. Held stable until i_cmd_ready; then go to RD_DATA.
- RD_DATA: direct pass-through: o_ext_valid=i_rd_valid, o_ext_data=i_rd_data, o_rd_ready=i_ext_ready. No buffering, zero latency. Results are pushed into the chunk FIFO (o_res_ready = FIFO not full). Go to WAIT_RES after the beat with i_rd_last.
- WAIT_RES: wait until the FIFO holds len results. The extension returns exactly one result per input, in order. Results may also arrive during RD_DATA.
- WR_CMD: same rules as RD_CMD with write=1 and the same addr. Go to WR_DATA on handshake.
- WR_DATA: o_wr_valid = FIFO not empty; o_wr_data = FIFO head; o_wr_last on beat len-1. Pop on handshake. Go to WR_RESP after the last beat.
- WR_RESP: on i_bresp_valid, apply addr += len*8, remaining -= len, points_done += len. If remaining == 0, go to DONE; otherwise go to RD_CMD.
- DONE: assert o_status_done (sticky), drop busy, return to IDLE in the same cycle. done rises 1 cycle after the final bresp, or 1 cycle after start when num_points==0.
- o_status_busy = 1 in every state except IDLE.
- o_cmd_valid must never drop before i_cmd_ready. Read and write bursts never overlap.
- The cfg inputs are sampled only at start; later changes do not affect the run in progress.

Optional Feature:
Macro ALFA_PC_SCHED_PERF_EN.
- Defined: 32-bit counter clears on start, increments every cycle busy=1, and saturates at 0xFFFF_FFFF. It drives o_perf_cycles and holds its value after done.
- Undefined: o_perf_cycles tied to 0 and no counter logic is built.

Decomposition:
- Package alfa_pc_sched_pkg: FSM state enum (IDLE, RD_CMD, RD_DATA, WAIT_RES, WR_CMD, WR_DATA, WR_RESP, DONE), point-field bit-position constants, POINT_BYTES=8.
- Sub-module alfa_pc_chunk_fifo: synchronous FIFO, depth BURST_LEN, width POINT_W, with full/empty flags and an occupancy count. Uses the same clock and reset.

Test Plan:
- num_points=1000, base=0x0, BURST_LEN=16, identity extension -> 63 read commands (62 with len=15, last with len=7 at addr 0x1F00). Matching write commands at the same addresses. Memory unchanged; done=1; points_done=1000.
- num_points=0, pc_ready 0->1 -> no commands issued; done=1 two cycles after the edge.
- Extension sets label=1 and randomly stalls ext_ready/res_valid 50% -> every written word equals its read word with label=1, in order.
- i_cmd_ready low for 10 cycles and i_wr_ready toggling -> command fields stable while valid. No lost or duplicated beats; o_wr_last only on beat 15.
- Reset asserted mid-WR_DATA, then a new run of 20 points -> outputs 0 during reset. New run issues reads of len 15 and 3; done=1.
- pc_ready edge during a run -> ignored, no restart. With ALFA_PC_SCHED_PERF_EN defined, o_perf_cycles equals the busy-cycle count.
